boot_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of the unified instruction/data RAM's data port. It holds the core in reset, receives a length-prefixed program image over a byte-wide valid/ready stream (e.g. from the UART receiver), and packs bytes big-endian into 32-bit words. It writes those words sequentially into RAM, then releases the core.

---
 rtl/boot_loader_pkg.sv | 59 +++++
 rtl/boot_word_packer.sv | 34 +++
 rtl/boot_loader.sv | 144 ++++++++++++++
 tb/tb_boot_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream boot loader.
package boot_loader_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_CHECK = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // Output flags held in registers alongside the state.
    typedef struct packed {
        logic ready;
        logic we;
        logic busy;
        logic done;
        logic err;
        logic core_rst;
    } flags_t;

    // Output flag values for a given state; loaded together with the state
    // so every output is a flop with no path from the byte stream.
    function automatic flags_t flags_for(state_t s);
        flags_t f;
        f = '0;
        f.core_rst = 1'b1;
        case (s)
            S_HDR: begin
                f.ready = 1'b1;
                f.busy  = 1'b1;
            end
            S_CHECK: f.busy = 1'b1;
            S_DATA: begin
                f.ready = 1'b1;
                f.busy  = 1'b1;
            end
            S_WRITE: begin
                f.busy = 1'b1;
                f.we   = WRITE_ENABLE;
            end
            S_DONE: begin
                f.done     = 1'b1;
                f.core_rst = 1'b0;
            end
            S_ERR: f.err = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; flags the 4th byte.
module boot_word_packer
    import boot_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    logic [1:0] cnt;

    // Completes a word on the edge that takes the 4th byte; the FSM uses
    // this to leave HDR/DATA on that same edge.
    assign word_valid = accept && (cnt == 2'd3);

    // Byte counter and shift register; first byte ends up in word[31:24].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            word <= ZERO;
        end else if (clear) begin
            cnt  <= 2'd0;
            word <= ZERO;
        end else if (accept) begin
            cnt  <= cnt + 2'd1;
            word <= {word[DATA_WIDTH-9:0], byte_in};
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: holds the core in reset, receives a length-prefixed image
// over a byte stream and writes it word by word into RAM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, core held in reset, waiting for start_i
// S_HDR   | collecting the 4-byte big-endian word count
// S_CHECK | one cycle: validate the word count
// S_DATA  | collecting the 4 bytes of the next payload word
// S_WRITE | one cycle: we_o high, addr_o/data_o presented to RAM
// S_DONE  | image loaded, core released; start_i begins a new session
// S_ERR   | bad length or stream timeout, core held; start_i retries
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 16384,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  we_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  core_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Down-counter of remaining idle cycles; zero with no accept means the
    // TIMEOUT_CYCLES-th consecutive idle cycle.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

    state_t                state;
    flags_t                flags;
    logic [TW-1:0]         timer;
    logic [31:0]           idx;
    logic [31:0]           len;
    logic                  accept;
    logic                  pack_clear;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;

    assign accept     = rx_valid_i && flags.ready;
    assign pack_clear = start_i && (state == S_IDLE || state == S_DONE || state == S_ERR);

    assign rx_ready_o = flags.ready;
    assign we_o       = flags.we;
    assign busy_o     = flags.busy;
    assign done_o     = flags.done;
    assign err_o      = flags.err;
    assign core_rst_o = flags.core_rst;
    assign data_o     = word;

    boot_word_packer u_packer (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .clear      (pack_clear),
        .accept     (accept),
        .byte_in    (rx_data_i),
        .word       (word),
        .word_valid (word_valid)
    );

    // Session FSM with its timeout counter, word index and write address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            flags  <= flags_for(S_IDLE);
            timer  <= TMO_LOAD;
            idx    <= 32'd0;
            len    <= 32'd0;
            addr_o <= BASE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state  <= S_HDR;
                        flags  <= flags_for(S_HDR);
                        timer  <= TMO_LOAD;
                        idx    <= 32'd0;
                        addr_o <= BASE;
                    end
                end
                S_HDR, S_DATA: begin
                    if (accept) begin
                        timer <= TMO_LOAD;
                        if (word_valid) begin
                            if (state == S_HDR) begin
                                state <= S_CHECK;
                                flags <= flags_for(S_CHECK);
                            end else begin
                                state <= S_WRITE;
                                flags <= flags_for(S_WRITE);
                            end
                        end
                    end else if (timer == '0) begin
                        state <= S_ERR;
                        flags <= flags_for(S_ERR);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CHECK: begin
                    len   <= word;
                    timer <= TMO_LOAD;
                    if (word == 32'd0) begin
                        state <= S_DONE;
                        flags <= flags_for(S_DONE);
                    end else if (word > 32'(MAX_WORDS)) begin
                        state <= S_ERR;
                        flags <= flags_for(S_ERR);
                    end else begin
                        state <= S_DATA;
                        flags <= flags_for(S_DATA);
                    end
                end
                S_WRITE: begin
                    idx    <= idx + 32'd1;
                    addr_o <= addr_o + ADDR_WIDTH'(4);
                    if (idx + 32'd1 == len) begin
                        state <= S_DONE;
                        flags <= flags_for(S_DONE);
                    end else begin
                        state <= S_DATA;
                        flags <= flags_for(S_DATA);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    flags <= flags_for(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table of sessions, random sessions,
// and hand-written sequences for latency, timeout and mid-session reset.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 8;
    localparam int          TMO  = 40;
    localparam int          WAIT_LIMIT = 200;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready_o;
    logic [31:0] addr_o;
    logic        we_o;
    logic [31:0] data_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    typedef struct {
        logic [31:0] len;
        int          max_gap;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    boot_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready_o),
        .addr_o     (addr_o),
        .we_o       (we_o),
        .data_o     (data_o),
        .core_rst_o (core_rst_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RAM-side monitor: log every write, ready must be low while writing.
    always @(negedge clk) begin
        if (rst_n && we_o) begin
            wr_addr_q.push_back(addr_o);
            wr_data_q.push_back(data_o);
            chk("ready_low_in_write", 32'(rx_ready_o), 32'd0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        rx_valid = 1'b1;
        rx_data  = b;
        w = 0;
        while (!rx_ready_o && w < WAIT_LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk("byte_accept_wait", 32'(w >= WAIT_LIMIT), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int g = 0; g < n; g++) @(negedge clk);
    endtask

    task automatic wait_not_busy();
        int w;
        w = 0;
        while (busy_o && w < WAIT_LIMIT) begin
            @(negedge clk);
            w++;
        end
        chk("session_end", 32'(busy_o), 32'd0);
    endtask

    // Full session against the model: a length outside 1..MAXW writes
    // nothing; otherwise word i of the image lands at BASE + 4*i.
    task automatic run_session(input logic [31:0] len, input int max_gap,
                               input bit exp_done, input bit exp_err);
        logic [7:0]  bytes_q[$];
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] wv;
        logic [7:0]  b;
        int          n_words;
        n_words = (len != 32'd0 && len <= 32'(MAXW)) ? int'(len) : 0;
        for (int i = 0; i < n_words; i++) begin
            wv = 32'd0;
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom);
                bytes_q.push_back(b);
                wv = wv * 256 + 32'(b);
            end
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(wv);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_done_clr", 32'(done_o), 32'd0);
        chk("start_err_clr", 32'(err_o), 32'd0);
        chk("start_core_rst", 32'(core_rst_o), 32'd1);
        send_byte(len[31:24]);
        send_byte(len[23:16]);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        foreach (bytes_q[i]) begin
            idle_cycles(int'($urandom_range(0, max_gap)));
            send_byte(bytes_q[i]);
        end
        wait_not_busy();
        chk("sess_done", 32'(done_o), 32'(exp_done));
        chk("sess_err", 32'(err_o), 32'(exp_err));
        chk("sess_core_rst", 32'(core_rst_o), 32'(!exp_done));
        chk("sess_write_count", 32'(wr_addr_q.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
            chk("sess_write_addr", wr_addr_q[i], exp_addr[i]);
            chk("sess_write_data", wr_data_q[i], exp_data[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] len_r;
        int          n_before;

        vecs[0] = '{len: 32'd0,           max_gap: 0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{len: 32'(MAXW + 1),   max_gap: 0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[2] = '{len: 32'd3,           max_gap: 5, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{len: 32'd1,           max_gap: 0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{len: 32'(MAXW),       max_gap: 3, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{len: 32'h8000_0000,   max_gap: 0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[6] = '{len: 32'hFFFF_FFFF,   max_gap: 2, exp_done: 1'b0, exp_err: 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle_cycles(2);

        // Reset values
        chk("rst_ready", 32'(rx_ready_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_core_rst", 32'(core_rst_o), 32'd1);
        chk("rst_addr", addr_o, BASE);
        chk("rst_data", data_o, 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Two-word reference image with continuous valid
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("w0_we", 32'(we_o), 32'd1);
        chk("w0_addr", addr_o, BASE);
        chk("w0_data", data_o, 32'hDEAD_BEEF);
        chk("w0_ready", 32'(rx_ready_o), 32'd0);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        chk("w1_we", 32'(we_o), 32'd1);
        chk("w1_addr", addr_o, BASE + 32'd4);
        chk("w1_data", data_o, 32'h0123_4567);
        @(negedge clk);
        chk("img2_done", 32'(done_o), 32'd1);
        chk("img2_core_rst", 32'(core_rst_o), 32'd0);
        chk("img2_busy", 32'(busy_o), 32'd0);
        chk("img2_we_low", 32'(we_o), 32'd0);
        chk("img2_writes", 32'(wr_addr_q.size()), 32'd2);

        // Table of sessions
        for (int v = 0; v < 7; v++)
            run_session(vecs[v].len, vecs[v].max_gap, vecs[v].exp_done, vecs[v].exp_err);

        // Random lengths, expectations from the length rule
        for (int r = 0; r < 4; r++) begin
            len_r = 32'($urandom_range(0, MAXW + 2));
            run_session(len_r, 4, len_r <= 32'(MAXW), len_r > 32'(MAXW));
        end

        // Stall after 2 bytes of word 1
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        send_byte(8'h11); send_byte(8'h22);
        idle_cycles(TMO - 1);
        chk("tmo_not_yet_err", 32'(err_o), 32'd0);
        chk("tmo_not_yet_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_core_rst", 32'(core_rst_o), 32'd1);
        chk("tmo_busy", 32'(busy_o), 32'd0);
        chk("tmo_writes", 32'(wr_addr_q.size()), 32'd1);
        if (wr_data_q.size() > 0) chk("tmo_word0", wr_data_q[0], 32'hCAFE_F00D);
        run_session(32'd2, 0, 1'b1, 1'b0);

        // Reset in the middle of DATA
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB);
        n_before = wr_addr_q.size();
        rx_valid = 1'b1;
        rx_data  = 8'hCC;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rx_ready_o), 32'd0);
        chk("mid_rst_we", 32'(we_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_core_rst", 32'(core_rst_o), 32'd1);
        chk("mid_rst_addr", addr_o, BASE);
        chk("mid_rst_data", data_o, 32'd0);
        idle_cycles(3);
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        idle_cycles(3);
        chk("post_rst_no_write", 32'(wr_addr_q.size()), 32'(n_before));
        chk("post_rst_idle", 32'(busy_o), 32'd0);
        chk("post_rst_done", 32'(done_o), 32'd0);
        run_session(32'd2, 1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
